// File: rtl/uart_pkg.sv
// Shared UART definitions: key-trigger FSM states and default timing constants,
// reused by uart_key_trigger and the sender/receiver blocks.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FIRE,
        HOLD,
        WAIT_REL
    } key_state_e;

    localparam int unsigned UART_CYCLES_PER_BIT = 10;
    localparam int unsigned UART_FRAME_BITS     = 10;

endpackage

// File: rtl/key_debounce.sv
// Button conditioner: two-flop synchroniser, polarity normalisation and a
// stability-count debouncer producing key_level (1 = pressed).
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 960,
    parameter bit          KEY_ACTIVE_LOW  = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic key_raw,
    output logic key_level
);

    localparam int unsigned CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic        RELEASED = KEY_ACTIVE_LOW;

    logic             sync1_q, sync2_q;
    logic             level_q, level_d;
    logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
    logic             synced;

    // Flops hold the raw pin value; normalise only after the synchroniser.
    assign synced = sync2_q ^ RELEASED;

    always_comb begin
        db_cnt_d = '0;
        level_d  = level_q;
        if (synced != level_q) begin
            if (db_cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                level_d = ~level_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q  <= RELEASED;
            sync2_q  <= RELEASED;
            db_cnt_q <= '0;
            level_q  <= 1'b0;
        end else begin
            sync1_q  <= key_raw;
            sync2_q  <= sync1_q;
            db_cnt_q <= db_cnt_d;
            level_q  <= level_d;
        end
    end

    assign key_level = level_q;

endmodule

// File: rtl/uart_key_trigger.sv
// Push-button to UART transmit trigger: one bit-long trigger per debounced press,
// then a frame+guard hold-off. Optional auto-repeat via UART_KEY_AUTO_REPEAT_EN.
module uart_key_trigger
    import uart_pkg::*;
#(
    parameter int unsigned CYCLES_PER_BIT  = UART_CYCLES_PER_BIT,
    parameter int unsigned FRAME_BITS      = UART_FRAME_BITS,
    parameter int unsigned GUARD_BITS      = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 960,
    parameter bit          KEY_ACTIVE_LOW  = 1'b1,
    parameter int unsigned REPEAT_CYCLES   = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_raw,
    output logic       key_level,
    output logic       trigger,
    output logic       busy,
    output logic [7:0] press_count
);

    localparam int unsigned FIRE_LOAD = CYCLES_PER_BIT - 1;
    localparam int unsigned HOLD_LOAD = (FRAME_BITS + GUARD_BITS) * CYCLES_PER_BIT - 1;
    localparam int unsigned TMR_W     = $clog2(HOLD_LOAD + 1);

    if (CYCLES_PER_BIT < 2 || DEBOUNCE_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_param_check
        $error("uart_key_trigger: CYCLES_PER_BIT, DEBOUNCE_CYCLES and REPEAT_CYCLES must be >= 2");
    end

    key_state_e       state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             level_prev_q;
    logic             press_evt;

`ifdef UART_KEY_AUTO_REPEAT_EN
    localparam int unsigned REP_W = $clog2(REPEAT_CYCLES);
    logic [REP_W-1:0] rep_q, rep_d;
`endif

    key_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .KEY_ACTIVE_LOW  (KEY_ACTIVE_LOW)
    ) u_debounce (
        .clk       (clk),
        .rst       (rst),
        .key_raw   (key_raw),
        .key_level (key_level)
    );

    assign press_evt = key_level & ~level_prev_q;

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        cnt_d   = cnt_q;
        trigger = 1'b0;
        busy    = 1'b0;
`ifdef UART_KEY_AUTO_REPEAT_EN
        rep_d   = rep_q;
`endif
        case (state_q)
            IDLE: begin
                if (press_evt) begin
                    state_d = FIRE;
                    tmr_d   = TMR_W'(FIRE_LOAD);
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            FIRE: begin
                trigger = 1'b1;
                busy    = 1'b1;
                if (tmr_q == '0) begin
                    state_d = HOLD;
                    tmr_d   = TMR_W'(HOLD_LOAD);
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            HOLD: begin
                busy = 1'b1;
                if (tmr_q == '0) begin
                    state_d = key_level ? WAIT_REL : IDLE;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            WAIT_REL: begin
`ifdef UART_KEY_AUTO_REPEAT_EN
                if (!key_level) begin
                    state_d = IDLE;
                    rep_d   = '0;
                end else if (rep_q == REP_W'(REPEAT_CYCLES - 1)) begin
                    state_d = FIRE;
                    tmr_d   = TMR_W'(FIRE_LOAD);
                    cnt_d   = cnt_q + 1'b1;
                    rep_d   = '0;
                end else begin
                    rep_d = rep_q + 1'b1;
                end
`else
                if (!key_level) begin
                    state_d = IDLE;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            tmr_q        <= '0;
            cnt_q        <= '0;
            level_prev_q <= 1'b0;
`ifdef UART_KEY_AUTO_REPEAT_EN
            rep_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            tmr_q        <= tmr_d;
            cnt_q        <= cnt_d;
            level_prev_q <= key_level;
`ifdef UART_KEY_AUTO_REPEAT_EN
            rep_q        <= rep_d;
`endif
        end
    end

    assign press_count = cnt_q;

endmodule

// File: tb/tb_uart_key_trigger.sv
// Self-checking bench for uart_key_trigger: timestamp-based reference model compared
// every cycle, plus directed literal checks; honours UART_KEY_AUTO_REPEAT_EN.
module tb_uart_key_trigger;

    localparam int CPB = 4;
    localparam int FB  = 10;
    localparam int GB  = 2;
    localparam int DB  = 8;
    localparam int REP = 50;
    localparam int HL  = (FB + GB) * CPB;
    localparam bit AL  = 1'b1;

    logic       clk     = 1'b0;
    logic       rst     = 1'b1;
    logic       key_raw = 1'b1;
    logic       key_level, trigger, busy;
    logic [7:0] press_count;

    int tests = 0;
    int fails = 0;

    uart_key_trigger #(
        .CYCLES_PER_BIT  (CPB),
        .FRAME_BITS      (FB),
        .GUARD_BITS      (GB),
        .DEBOUNCE_CYCLES (DB),
        .KEY_ACTIVE_LOW  (AL),
        .REPEAT_CYCLES   (REP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_raw     (key_raw),
        .key_level   (key_level),
        .trigger     (trigger),
        .busy        (busy),
        .press_count (press_count)
    );

    always #5 clk = ~clk;

    // Reference model: edge-numbered timestamps rather than counters/states.
    int       n        = 0;
    bit       s1       = 0, s2 = 0;
    bit       m_level  = 0, m_prev = 0;
    int       run      = 0;
    int       fire_t   = -1, busy_end = -1;
    bit       wait_rel = 0;
    int       rep      = 0;
    logic [7:0] m_count = '0;
    bit       e_trig   = 0, e_busy = 0;
    bit       press;

    task automatic model_fire(input int e);
        fire_t   = e;
        busy_end = e + CPB + HL;
        m_count  = m_count + 8'd1;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 = 0; s2 = 0; m_level = 0; m_prev = 0; run = 0;
            fire_t = -1; busy_end = -1; wait_rel = 0; rep = 0;
            m_count = '0; e_trig = 0; e_busy = 0;
        end else begin
            n++;
            press = m_level && !m_prev;
            if (fire_t >= 0 && n <= busy_end) begin
                if (n == busy_end) wait_rel = m_level;
            end else if (wait_rel) begin
                if (!m_level) begin
                    wait_rel = 0;
                    rep = 0;
                end
`ifdef UART_KEY_AUTO_REPEAT_EN
                else begin
                    rep++;
                    if (rep == REP) begin
                        rep = 0;
                        wait_rel = 0;
                        model_fire(n);
                    end
                end
`endif
            end else if (press) begin
                model_fire(n);
            end
            e_trig = (fire_t >= 0) && (n >= fire_t) && (n < fire_t + CPB);
            e_busy = (fire_t >= 0) && (n >= fire_t) && (n < busy_end);
            m_prev = m_level;
            if (s2 != m_level) begin
                run++;
                if (run == DB) begin
                    m_level = !m_level;
                    run = 0;
                end
            end else begin
                run = 0;
            end
            s2 = s1;
            s1 = key_raw ^ AL;
        end
    end

    always @(negedge clk) begin
        tests++;
        if ({key_level, trigger, busy, press_count} !== {m_level, e_trig, e_busy, m_count}) begin
            fails++;
            if (fails < 30)
                $display("FAIL model_cmp t=%0t: got lvl=%b trig=%b busy=%b cnt=%0d, expected lvl=%b trig=%b busy=%b cnt=%0d",
                         $time, key_level, trigger, busy, press_count, m_level, e_trig, e_busy, m_count);
        end
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s t=%0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic wait_n(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        wait_n(2);
        rst = 1'b0;
    endtask

    int seen;
    int base;

    initial begin
        // Reset values
        wait_n(3);
        check("reset_level", key_level, 0);
        check("reset_trigger", trigger, 0);
        check("reset_busy", busy, 0);
        check("reset_count", press_count, 0);
        rst = 1'b0;
        wait_n(20);

        // Clean press: level at +2+DB, trigger for CPB cycles, busy until +1+CPB+HL+DB+2
        @(negedge clk); key_raw = 1'b0;
        wait_n(9);  check("lvl_before_db", key_level, 0);
        wait_n(1);  check("lvl_rise", key_level, 1);
                    check("trig_before", trigger, 0);
        wait_n(1);  check("trig_rise", trigger, 1);
                    check("cnt_first", press_count, 1);
        wait_n(3);  check("trig_last", trigger, 1);
        wait_n(1);  check("trig_fall", trigger, 0);
                    check("busy_in_hold", busy, 1);
        wait_n(47); check("busy_last", busy, 1);
        wait_n(1);  check("busy_fall", busy, 0);
        wait_n(17); key_raw = 1'b1;
        wait_n(30);

        // Glitch one cycle shorter than the debounce window
        key_raw = 1'b0;
        wait_n(DB - 1);
        key_raw = 1'b1;
        seen = 0;
        repeat (20) begin @(negedge clk); seen |= int'(key_level); end
        check("glitch_level", seen, 0);

        // Bounce then stable press
        for (int i = 0; i < 20; i++) begin
            key_raw = ~key_raw;
            wait_n(3);
        end
        key_raw = 1'b0;
        wait_n(80);
        check("bounce_count", press_count, 2);
        key_raw = 1'b1;
        wait_n(30);

        // Rapid re-press inside the hold-off is dropped
        key_raw = 1'b0; wait_n(15);
        key_raw = 1'b1; wait_n(15);
        key_raw = 1'b0; wait_n(50);
        check("repress_dropped", press_count, 3);
        key_raw = 1'b1; wait_n(30);
        key_raw = 1'b0; wait_n(20);
        check("repress_after_holdoff", press_count, 4);
        key_raw = 1'b1; wait_n(80);

        // Long hold: auto-repeat adds one trigger within this window
        key_raw = 1'b0; wait_n(130);
        key_raw = 1'b1; wait_n(100);
`ifdef UART_KEY_AUTO_REPEAT_EN
        check("hold_repeat_count", press_count, 6);
`else
        check("hold_single_count", press_count, 5);
`endif

        // Asynchronous reset on the fourth trigger cycle
        key_raw = 1'b0;
        wait_n(13);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("rst_trigger", trigger, 0);
        check("rst_busy", busy, 0);
        check("rst_level", key_level, 0);
        check("rst_count", press_count, 0);
        @(negedge clk);
        wait_n(2);
        rst = 1'b0;
        seen = 0;
        repeat (10) begin @(negedge clk); seen |= int'(trigger); end
        check("no_trig_during_redebounce", seen, 0);
        wait_n(80);
        key_raw = 1'b1;
        wait_n(40);

        // Counter wrap
        do_reset();
        wait_n(5);
        for (int i = 0; i < 256; i++) begin
            key_raw = 1'b0; wait_n(70);
            key_raw = 1'b1; wait_n(25);
        end
        check("wrap_to_zero", press_count, 0);
        key_raw = 1'b0; wait_n(70);
        check("wrap_next", press_count, 1);
        key_raw = 1'b1; wait_n(25);

        // Randomised button activity
        base = tests;
        for (int i = 0; i < 80; i++) begin
            key_raw = 1'($urandom_range(0, 1));
            wait_n(int'($urandom_range(1, 60)));
        end
        key_raw = 1'b1;
        wait_n(300);
        check("random_cycles_checked", (tests - base) > 1000, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
